sweep_classify: RTL and testbench

- Collects one magnitude sample per frequency-sweep step (N_PTS steps) from the learn/FFT path, buffers them and finds the peak.
- Compares every point against a programmable fraction of the peak (−3 dB by default) and classifies the response as low-pass, high-pass, band-pass or band-stop.
- Drives filter_type, one-hot LEDs and status for the display path.
- Parametrised successor to the fixed 4-type decoder: configurable sweep length, magnitude width and threshold, plus error reporting, peak reporting and abort.

---
 rtl/sweep_classify_if.sv | 28 ++
 rtl/sweep_classify.sv | 134 +++++++++++++
 tb/tb_sweep_classify.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sweep_classify_if.sv
// sweep_classify_if: control, sample stream and result bundle for the sweep classifier.
interface sweep_classify_if #(
   parameter int MAG_W = 16,
   parameter int IDX_W = 6
) ();
   logic             start;
   logic             abort;
   logic             mag_valid;
   logic [MAG_W-1:0] mag_data;
   logic             mag_ready;
   logic             busy;
   logic             done;
   logic [2:0]       filter_type;
   logic [3:0]       led;
   logic [IDX_W-1:0] peak_idx;
   logic [MAG_W-1:0] peak_mag;
   logic             err;

   modport master (
      output start, abort, mag_valid, mag_data,
      input  mag_ready, busy, done, filter_type, led, peak_idx, peak_mag, err
   );

   modport slave (
      input  start, abort, mag_valid, mag_data,
      output mag_ready, busy, done, filter_type, led, peak_idx, peak_mag, err
   );
endinterface

// File: rtl/sweep_classify.sv
// sweep_classify: buffers one sweep of magnitudes, thresholds against a fraction of the peak
// and classifies the response as LP/HP/BP/BS.
module sweep_classify #(
   parameter int MAG_W   = 16,
   parameter int N_PTS   = 64,
   parameter int IDX_W   = 6,
   parameter int THR_NUM = 181
) (
   input logic clk_50m,
   input logic rst_n,
   sweep_classify_if.slave bus
);
   localparam int SC_W = IDX_W + 2;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PTS - 1);
   localparam logic [SC_W-1:0] N_SC = SC_W'(N_PTS);
   localparam logic [SC_W-1:0] N_SC1 = SC_W'(N_PTS + 1);

   typedef enum logic [2:0] {IDLE, COLLECT, THRESH, SCAN, DONE} state_t;

   state_t           state;
   logic [MAG_W-1:0] mem [N_PTS];
   logic [MAG_W-1:0] rdata, max_v, thr;
   logic [IDX_W-1:0] cnt, max_idx;
   logic [SC_W-1:0]  sc;
   logic [1:0]       edges;
   logic             first_pass, prev_pass, pass, accept, cls_err;
   logic [MAG_W+7:0] prod;
   logic [2:0]       cls_type;
   logic [3:0]       cls_led;

   assign accept = (state == COLLECT) && bus.mag_valid && !bus.abort;
   assign pass   = rdata >= thr;
   assign prod   = {8'd0, max_v} * (MAG_W+8)'(THR_NUM);

   always_comb begin
      cls_type = (max_v == '0)  ? 3'd0 :
                 (edges == 2'd1) ? (first_pass ? 3'd1 : 3'd2) :
                 (edges == 2'd2) ? (first_pass ? 3'd4 : 3'd3) : 3'd0;
      cls_err  = (max_v == '0) || (edges == 2'd3);
      cls_led  = (cls_type == 3'd1) ? 4'b0001 :
                 (cls_type == 3'd2) ? 4'b0010 :
                 (cls_type == 3'd3) ? 4'b0100 :
                 (cls_type == 3'd4) ? 4'b1000 : 4'b0000;
   end

   // Reset-free so the buffer maps onto a synchronous-read RAM.
   always_ff @(posedge clk_50m) begin
      if (accept) mem[cnt] <= bus.mag_data;
      rdata <= mem[sc[IDX_W-1:0]];
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         bus.mag_ready   <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.filter_type <= 3'd0;
         bus.led         <= 4'd0;
         bus.err         <= 1'b0;
         bus.peak_idx    <= '0;
         bus.peak_mag    <= '0;
         cnt             <= '0;
         max_v           <= '0;
         max_idx         <= '0;
         thr             <= '0;
         sc              <= '0;
         edges           <= 2'd0;
         first_pass      <= 1'b0;
         prev_pass       <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (bus.abort) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.mag_ready <= 1'b0;
         end else begin
            case (state)
               IDLE: if (bus.start) begin
                  state         <= COLLECT;
                  bus.busy      <= 1'b1;
                  bus.mag_ready <= 1'b1;
                  cnt           <= '0;
                  max_v         <= '0;
                  max_idx       <= '0;
               end
               COLLECT: if (bus.mag_valid) begin
                  cnt <= cnt + 1'b1;
                  if (bus.mag_data > max_v) begin
                     max_v   <= bus.mag_data;
                     max_idx <= cnt;
                  end
                  if (cnt == LAST) begin
                     state         <= THRESH;
                     bus.mag_ready <= 1'b0;
                  end
               end
               THRESH: begin
                  thr   <= prod[MAG_W+7:8];
                  sc    <= '0;
                  state <= SCAN;
               end
               SCAN: begin
                  sc <= sc + 1'b1;
                  // rdata holds buf[sc-1] while 1 <= sc <= N_PTS
                  if (sc != '0 && sc <= N_SC) begin
                     prev_pass <= pass;
                     if (sc == SC_W'(1)) begin
                        first_pass <= pass;
                        edges      <= 2'd0;
                     end else if (pass != prev_pass && edges != 2'd3) begin
                        edges <= edges + 2'd1;
                     end
                  end
                  if (sc == N_SC1) begin
                     state           <= DONE;
                     bus.done        <= 1'b1;
                     bus.filter_type <= cls_type;
                     bus.led         <= cls_led;
                     bus.err         <= cls_err;
                     bus.peak_idx    <= max_idx;
                     bus.peak_mag    <= max_v;
                  end
               end
               DONE: begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sweep_classify.sv
// tb_sweep_classify: directed sweeps with hand-computed classifications for an 8-point build.
module tb_sweep_classify;
   typedef logic [15:0] vec_t [8];

   logic clk_50m = 1'b0;
   logic rst_n   = 1'b0;
   int   n_chk   = 0;
   int   n_pass  = 0;
   int   n_done  = 0;
   int   lat, d0;

   always #5 clk_50m = ~clk_50m;

   sweep_classify_if #(.MAG_W(16), .IDX_W(3)) bus ();

   sweep_classify #(.MAG_W(16), .N_PTS(8), .IDX_W(3), .THR_NUM(181)) dut (
      .clk_50m(clk_50m),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always @(posedge clk_50m) if (bus.done) n_done++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_50m);
      #1;
   endtask

   task automatic start_sweep();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic feed(input vec_t s, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         bus.mag_valid = 1'b1;
         bus.mag_data  = s[i];
         tick();
         bus.mag_valid = 1'b0;
         if (i < n - 1) repeat (gap) tick();
      end
   endtask

   task automatic wait_done(output int l);
      l = 0;
      while (!bus.done && l < 40) begin
         tick();
         l++;
      end
   endtask

   task automatic sweep(input string tag, input vec_t s, input int gap, input logic [2:0] ft,
                        input logic [3:0] ld, input logic [2:0] idx, input logic [15:0] pk,
                        input logic e, output int l);
      start_sweep();
      feed(s, 8, gap);
      check({tag, "_ready_low"}, bus.mag_ready, 1'b0);
      wait_done(l);
      check({tag, "_done"}, bus.done, 1'b1);
      check({tag, "_type"}, bus.filter_type, ft);
      check({tag, "_led"}, bus.led, ld);
      check({tag, "_idx"}, bus.peak_idx, idx);
      check({tag, "_mag"}, bus.peak_mag, pk);
      check({tag, "_err"}, bus.err, e);
      tick();
      check({tag, "_idle"}, bus.busy, 1'b0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.mag_valid = 1'b0;
      bus.mag_data = '0;
      repeat (3) @(posedge clk_50m);
      #1;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_ready", bus.mag_ready, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_type", bus.filter_type, 3'd0);
      check("rst_led", bus.led, 4'd0);
      check("rst_err", bus.err, 1'b0);
      check("rst_mag", bus.peak_mag, 16'd0);
      @(negedge clk_50m) rst_n = 1'b1;
      tick();

      sweep("lp", '{1000, 1000, 1000, 500, 100, 50, 20, 10}, 0, 3'd1, 4'b0001, 3'd0, 16'd1000, 1'b0, lat);
      check("lp_latency", lat, 11);
      sweep("hp", '{10, 20, 50, 100, 500, 1000, 1000, 1000}, 3, 3'd2, 4'b0010, 3'd5, 16'd1000, 1'b0, lat);
      sweep("bs", '{1000, 990, 100, 20, 80, 950, 1000, 1000}, 0, 3'd4, 4'b1000, 3'd0, 16'd1000, 1'b0, lat);
      sweep("zero", '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 3'd0, 4'b0000, 3'd0, 16'd0, 1'b1, lat);
      sweep("sat", '{1000, 0, 1000, 0, 1000, 0, 1000, 0}, 1, 3'd0, 4'b0000, 3'd0, 16'd1000, 1'b1, lat);
      sweep("bp", '{10, 50, 800, 1000, 900, 60, 20, 10}, 0, 3'd3, 4'b0100, 3'd3, 16'd1000, 1'b0, lat);

      // abort mid-collect leaves the BP result in place
      d0 = n_done;
      start_sweep();
      feed('{5000, 1, 1, 1, 0, 0, 0, 0}, 4, 0);
      check("ab_busy_pre", bus.busy, 1'b1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("ab_busy", bus.busy, 1'b0);
      check("ab_ready", bus.mag_ready, 1'b0);
      check("ab_type", bus.filter_type, 3'd3);
      check("ab_mag", bus.peak_mag, 16'd1000);
      repeat (20) tick();
      check("ab_no_done", n_done - d0, 0);

      // start while busy is ignored
      d0 = n_done;
      start_sweep();
      feed('{10, 50, 800, 0, 0, 0, 0, 0}, 3, 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      feed('{1000, 900, 60, 20, 10, 0, 0, 0}, 5, 0);
      wait_done(lat);
      check("sb_type", bus.filter_type, 3'd3);
      repeat (20) tick();
      check("sb_one_done", n_done - d0, 1);
      check("sb_busy", bus.busy, 1'b0);

      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("sa_busy", bus.busy, 1'b0);
      check("sa_ready", bus.mag_ready, 1'b0);

      // async reset mid-scan
      start_sweep();
      feed('{1000, 1000, 1000, 500, 100, 50, 20, 10}, 8, 0);
      repeat (4) tick();
      check("mr_busy_pre", bus.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mr_type", bus.filter_type, 3'd0);
      check("mr_led", bus.led, 4'd0);
      check("mr_mag", bus.peak_mag, 16'd0);
      check("mr_idx", bus.peak_idx, 3'd0);
      check("mr_busy", bus.busy, 1'b0);
      check("mr_done", bus.done, 1'b0);
      @(negedge clk_50m) rst_n = 1'b1;
      repeat (15) tick();
      check("mr_ready_after", bus.mag_ready, 1'b0);
      check("mr_busy_after", bus.busy, 1'b0);
      check("mr_type_after", bus.filter_type, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
